// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared states, error codes, funct3 encodings and size helpers for the LSU
package load_store_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGNED, ERR_ILLEGAL, ERR_TIMEOUT} lsu_err_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;
  // byte-lane mask for an access size (funct3[1:0])
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? MASK_B : (sz == 2'd1) ? MASK_H : (sz == 2'd2) ? MASK_W : MASK_D;
  endfunction
  // address bits that must be zero for a naturally aligned access of this size
  function automatic logic [2:0] align_bits(input logic [1:0] sz);
    return (sz == 2'd0) ? 3'b000 : (sz == 2'd1) ? 3'b001 : (sz == 2'd2) ? 3'b011 : 3'b111;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and memory bus signals of the LSU
interface load_store_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_data;
  logic [1:0]        resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the addressed lanes of a memory word down and sign/zero-extends them
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              rdata,
  input  logic [$clog2(XLEN/8)-1:0]    offset,
  input  logic [2:0]                   funct3,
  output logic [XLEN-1:0]              result
);
  logic [XLEN-1:0] sh;
  // bring the addressed byte to lane 0, then extend by access type; LD passes through
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    result = (funct3 == F3_LB)  ? XLEN'($signed(sh[7:0])) :
             (funct3 == F3_LH)  ? XLEN'($signed(sh[15:0])) :
             (funct3 == F3_LW)  ? XLEN'($signed(sh[31:0])) :
             (funct3 == F3_LBU) ? XLEN'(sh[7:0]) :
             (funct3 == F3_LHU) ? XLEN'(sh[15:0]) :
             (funct3 == F3_LWU) ? XLEN'(sh[31:0]) : sh;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine with byte lanes, variable latency and timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam int TL = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TLIM = CW'(TL);
  lsu_state_t        state_q, state_d;
  lsu_err_t          err_q, err_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   load_val;
  logic [OW-1:0]     off;
  logic              illegal, misaligned, timed_out;

  assign off = addr_q[OW-1:0];
  assign illegal = (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]) ||
                   (XLEN == 32 && (bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == F3_LWU));
  assign misaligned = |(bus.req_addr[2:0] & align_bits(bus.req_funct3[1:0]));
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q >= TLIM);

  assign bus.req_ready  = state_q == S_IDLE;
  assign bus.resp_valid = state_q == S_RESP;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_req    = state_q == S_REQ;
  assign bus.mem_we     = bus.mem_req & we_q;
  assign bus.mem_addr   = bus.mem_req ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
  assign bus.mem_be     = bus.mem_req ? NB'(size_mask(f3_q[1:0])) << off : '0;
  assign bus.mem_wdata  = bus.mem_req ? wdata_q << {off, 3'b000} : '0;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (bus.mem_rdata),
    .offset (off),
    .funct3 (f3_q),
    .result (load_val)
  );

  // next-state logic; response registers only change on the transition into RESP
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = (illegal || misaligned) ? S_RESP : S_REQ;
          if (illegal || misaligned) begin
            err_d  = illegal ? ERR_ILLEGAL : ERR_MISALIGNED;
            data_d = '0;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          state_d = we_q ? S_RESP : S_WAIT;
          if (we_q) begin
            err_d  = ERR_NONE;
            data_d = '0;
          end
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = ERR_TIMEOUT;
          data_d  = '0;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = S_RESP;
          err_d   = ERR_NONE;
          data_d  = load_val;
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = ERR_TIMEOUT;
          data_d  = '0;
        end
      end
      S_RESP: state_d = S_IDLE;
    endcase
  end

  // state and request registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
